// File: rtl/booth_sched_pkg.sv
// booth_sched_pkg: shared types and widths for the booth multiplier scheduler
package booth_sched_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
    localparam int OPW         = 8;
    localparam int PRODW       = 16;
    localparam int IDW         = 3;
    localparam int LATENCY_DEF = 5;
endpackage

// File: rtl/booth_rr_arb.sv
// booth_rr_arb: combinational round-robin grant searching upward from ptr+1 with wrap
module booth_rr_arb
    import booth_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    // walk offsets from farthest to nearest so the nearest set request after ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NREQ; i >= 1; i--)
            for (int k = 0; k < NREQ; k++)
                if (k == (int'(ptr) + i) % NREQ && req[k]) begin
                    grant    = '0;
                    grant[k] = 1'b1;
                    idx      = IDW'(k);
                end
    end
    assign any = |req;
endmodule

// File: rtl/booth_mult_sched.sv
// booth_mult_sched: round-robin scheduler for one shared sequential radix-4 booth multiplier (optional ZERO_SKIP_EN)
module booth_mult_sched
    import booth_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [PRODW-1:0]    rsp_prod,
    output logic [OPW-1:0]      mul_a,
    output logic [OPW-1:0]      mul_b,
    output logic                mul_load,
    input  logic [PRODW-1:0]    mul_prod,
    output logic                busy
);
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [OPW-1:0]    a_q, a_d, b_q, b_d;
    logic [PRODW-1:0]  prod_q, prod_d;
    logic              rv_q, rv_d;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gidx;
    logic              gany;
    logic [OPW-1:0]    ga, gb;

    booth_rr_arb #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // select the granted requester's operands without a variable part-select
    always_comb begin
        ga = '0;
        gb = '0;
        for (int k = 0; k < NREQ; k++)
            if (grant[k]) begin
                ga = req_a[k*OPW +: OPW];
                gb = req_b[k*OPW +: OPW];
            end
    end

    // next-state and datapath: operands latched on accept and held until the next accept
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rv_d    = rv_q;
        case (state_q)
            IDLE: if (gany) begin
                a_d     = ga;
                b_d     = gb;
                ptr_d   = gidx;
                id_d    = gidx;
                state_d = LOAD;
`ifdef ZERO_SKIP_EN
                if (ga == '0 || gb == '0) begin
                    prod_d  = '0;
                    rv_d    = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(LATENCY - 1)) begin
                    prod_d  = mul_prod;
                    rv_d    = 1'b1;
                    state_d = DONE;
                end
            end
            default: if (rsp_ready) begin
                rv_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // controller state and registers; rst aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rv_q    <= rv_d;
        end
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign mul_load  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign rsp_valid = rv_q;
    assign rsp_id    = id_q;
    assign rsp_prod  = prod_q;
endmodule

// File: doc/booth_mult_sched.md
Name: booth_mult_sched

Overview:
Round-robin scheduler sharing one sequential radix-4 booth unsigned multiplier (8x8->16) between NREQ requesters.
Accepts one request at a time over valid/ready and drives the multiplier's operand and load inputs.
Holds operands stable for the whole operation, counts the digit cycles, then captures the product.
Returns the product with the requester id over a valid/ready response channel.

Parameters:
NREQ, 4, number of requesters (2..8)
LATENCY, 5, cycles from the cycle after mul_load until mul_prod is final (5 radix-4 digits of the 10-bit zero-extended multiplier)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_a  in  8*NREQ  multiplicands, requester i at [8i+7:8i]
req_b  in  8*NREQ  multipliers, same packing
req_ready  out  NREQ  one-hot accept pulse
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  3  index of the requester served
rsp_prod  out  16  product
mul_a  out  8  to multiplier a
mul_b  out  8  to multiplier b
mul_load  out  1  to multiplier load
mul_prod  in  16  from multiplier prod
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; cycle counter 0; round-robin pointer = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE, any req_valid set:
  - grant the first set bit searching from pointer+1 upward with wrap.
  - req_ready[g]=1 for this cycle only; a request is accepted when req_valid & req_ready are both high.
  - register mul_a/mul_b from requester g; pointer<=g; id<=g; go to LOAD.
- LOAD: mul_load=1 for exactly one cycle; counter<=0; go to RUN.
- RUN:
  - counter increments each cycle.
  - when counter==LATENCY-1: rsp_prod<=mul_prod, rsp_valid<=1, go to DONE.
  - accept-to-rsp_valid latency = LATENCY+2 cycles.
- DONE: hold rsp_valid/rsp_id/rsp_prod stable until rsp_ready; on handshake, rsp_valid<=0 and go to IDLE.
- Exactly one request outstanding; req_ready stays 0 outside IDLE.
- mul_a/mul_b change only on acceptance and are held through LOAD, RUN and DONE, because the multiplier reads a every cycle.
- mul_load is never asserted outside LOAD.
- A requester dropping req_valid before it is granted is legal; the arbiter simply skips it.
- Back-to-back requests from the same requester get no priority over others waiting; round-robin fairness is guaranteed.
- rst mid-operation aborts immediately: the response is lost and the multiplier is expected to be reset by the same rst.
- Width: the product is 16-bit unsigned with no overflow (255*255=65025 fits).

Optional Feature:
ZERO_SKIP_EN:
- Defined: in IDLE, if the granted a==0 or b==0, go directly to DONE with rsp_prod=0; LOAD/RUN are skipped and mul_load is not pulsed (accept-to-rsp_valid = 1 cycle).
- Undefined: zero operands take the normal path with LATENCY+2 latency.

Decomposition:
- Package booth_sched_pkg: state enum (IDLE, LOAD, RUN, DONE), OPW=8, PRODW=16, IDW=3, default LATENCY.
- Sub-module booth_rr_arb: combinational round-robin grant, inputs req vector and pointer, outputs one-hot grant and encoded index.
- Controller, counter and registers stay in booth_mult_sched.

Test Plan:
- Single request, requester 0 a=255 b=230 -> req_ready[0] pulses once; mul_load one cycle; rsp_valid 7 cycles after accept; rsp_prod=58650, rsp_id=0.
- Requesters 0,1,2 valid together (5*9, 150*100, 200*250) -> served in order 0,1,2; products 45, 15000, 50000; ids match.
- rsp_ready held low 10 cycles after a=233 b=111 -> rsp_prod=25863 held stable, busy=1, no req_ready to a waiting requester 3 until the handshake.
- Requester 1 holds req_valid continuously while requester 3 also requests -> grants alternate 1,3,1,3.
- rst asserted in RUN cycle 2 -> all outputs 0 immediately; next request a=55 b=46 completes with 2530.
- a=0 b=77 -> with ZERO_SKIP_EN: rsp_valid next cycle, prod 0, no mul_load; without it: normal latency, prod 0.
